// File: rtl/flag_pkg.sv
// Shared constants for the flag controller: condition codes and flag bit positions.
// Pure declarations plus one combinational helper; no latency.
// No flow control lives here.
package flag_pkg;

    localparam int FLAG_W = 3;

    // Bit positions inside a packed {zf,sf,cf} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0] COND_AL = 3'd0;
    localparam logic [2:0] COND_EQ = 3'd1;
    localparam logic [2:0] COND_NE = 3'd2;
    localparam logic [2:0] COND_LT = 3'd3;
    localparam logic [2:0] COND_GE = 3'd4;
    localparam logic [2:0] COND_CS = 3'd5;
    localparam logic [2:0] COND_CC = 3'd6;
    localparam logic [2:0] COND_NV = 3'd7;

    // Evaluate a branch condition code against a flag vector
    function automatic logic cond_true(input logic [2:0] code, input logic [FLAG_W-1:0] f);
        logic res;
        res = 1'b0;
        case (code)
            COND_AL: res = 1'b1;
            COND_EQ: res = f[FLAG_Z];
            COND_NE: res = ~f[FLAG_Z];
            COND_LT: res = f[FLAG_S];
            COND_GE: res = ~f[FLAG_S];
            COND_CS: res = f[FLAG_C];
            COND_CC: res = ~f[FLAG_C];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag sets used across interrupt entry/exit.
// Push/pop take effect on the next edge; dout shows the top entry combinationally.
// Push when full and pop when empty are ignored; the caller flags the error.
module flag_stack
    import flag_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] dout,
    output logic [PW:0]       depth,
    output logic              full,
    output logic              empty
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [FLAG_W-1:0] mem_q [DEPTH];
    logic [PW:0]       ptr_q;
    logic [PW:0]       ptr_d;
    logic [PW-1:0]     top_idx;
    logic              do_push;
    logic              do_pop;

    assign full    = (ptr_q == FULL_CNT);
    assign empty   = (ptr_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign top_idx = ptr_q[PW-1:0] - PW'(1);
    assign dout    = mem_q[top_idx];
    assign depth   = ptr_q;

    // Pointer next state: at most one of push/pop is asserted by the caller
    always_comb begin
        ptr_d = ptr_q;
        if (do_push) begin
            ptr_d = ptr_q + (PW+1)'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - (PW+1)'(1);
        end
    end

    // Only the pointer is reset; stale entries are unreachable once it is zero
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entry storage, written at the current pointer on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[ptr_q[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/flag_ctrl.sv
// Owns zf/sf/cf, arbitrates restore vs ALU writes, saves/restores via a LIFO, evaluates branch conditions.
// Flags, take and take_vld update one edge after the request; conditions see the forwarded next flags.
// A restore that actually pops stalls a same-cycle ALU write (alu_stall); the ALU holds and retries.
module flag_ctrl
    import flag_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          alu_we,
    input  logic [2:0]    alu_mask,
    input  logic          alu_zf,
    input  logic          alu_sf,
    input  logic          alu_cf,
    input  logic          save,
    input  logic          restore,
    input  logic          cond_vld,
    input  logic [2:0]    cond,
    output logic          zf,
    output logic          sf,
    output logic          cf,
    output logic          take,
    output logic          take_vld,
    output logic          alu_stall,
    output logic [PW:0]   depth,
    output logic          ovf,
    output logic          unf
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] alu_vals;
    logic [FLAG_W-1:0] pop_dat;
    logic              take_q;
    logic              take_vld_q;
    logic              ovf_q;
    logic              unf_q;
    logic              push_req;
    logic              pop_req;
    logic              push_ok;
    logic              pop_ok;
    logic              stk_full;
    logic              stk_empty;

    // save and restore together cancel each other out
    assign push_req = save & ~restore;
    assign pop_req  = restore & ~save;
    assign push_ok  = push_req & ~stk_full;
    assign pop_ok   = pop_req & ~stk_empty;

    // Only a restore that really pops wins over the ALU
    assign alu_stall = alu_we & pop_ok;

    assign alu_vals = {alu_zf, alu_sf, alu_cf};

    flag_stack #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_stack (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (flags_q),
        .dout  (pop_dat),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-flag selection: popped entry, else masked ALU merge, else hold
    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = pop_dat;
        end else if (alu_we) begin
            flags_d = (alu_mask & alu_vals) | (~alu_mask & flags_q);
        end
    end

    // Architectural flags, condition result and sticky errors
    always_ff @(posedge clk) begin
        if (!clrn) begin
            flags_q    <= '0;
            take_q     <= 1'b0;
            take_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            take_q     <= cond_vld & cond_true(cond, flags_d);
            take_vld_q <= cond_vld;
            ovf_q      <= ovf_q | (push_req & stk_full);
            unf_q      <= unf_q | (pop_req & stk_empty);
        end
    end

    assign zf       = flags_q[FLAG_Z];
    assign sf       = flags_q[FLAG_S];
    assign cf       = flags_q[FLAG_C];
    assign take     = take_q;
    assign take_vld = take_vld_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl against a queue-based reference model.
// Directed scenarios followed by randomized traffic with occasional resets.
// Inputs change just after the rising edge; outputs are sampled 1 time unit after it.
module tb_flag_ctrl;

    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic          clk = 1'b0;
    logic          clrn;
    logic          alu_we;
    logic [2:0]    alu_mask;
    logic          alu_zf, alu_sf, alu_cf;
    logic          save, restore;
    logic          cond_vld;
    logic [2:0]    cond;
    logic          zf, sf, cf;
    logic          take, take_vld;
    logic          alu_stall;
    logic [PW:0]   depth;
    logic          ovf, unf;

    always #5 clk = ~clk;

    flag_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .alu_we    (alu_we),
        .alu_mask  (alu_mask),
        .alu_zf    (alu_zf),
        .alu_sf    (alu_sf),
        .alu_cf    (alu_cf),
        .save      (save),
        .restore   (restore),
        .cond_vld  (cond_vld),
        .cond      (cond),
        .zf        (zf),
        .sf        (sf),
        .cf        (cf),
        .take      (take),
        .take_vld  (take_vld),
        .alu_stall (alu_stall),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [2:0] m_f;
    logic [2:0] m_stk[$];
    logic       m_ovf, m_unf, m_take, m_tv;
    logic       exp_stall, obs_stall;

    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[2];
            3'd2:    return !f[2];
            3'd3:    return f[1];
            3'd4:    return !f[1];
            3'd5:    return f[0];
            3'd6:    return !f[0];
            default: return 1'b0;
        endcase
    endfunction

    // Apply one cycle of inputs, capture alu_stall before the edge, advance model and clock
    task automatic cyc(input logic rn, input logic we, input logic [2:0] mask, input logic [2:0] vals,
                       input logic sv, input logic rs, input logic cv, input logic [2:0] cc);
        logic [2:0] nf;
        logic       popped;
        clrn = rn; alu_we = we; alu_mask = mask; {alu_zf, alu_sf, alu_cf} = vals;
        save = sv; restore = rs; cond_vld = cv; cond = cc;
        #1;
        obs_stall = alu_stall;
        exp_stall = we && rs && !sv && (m_stk.size() > 0);
        if (!rn) begin
            m_f = 3'b000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_take = 1'b0; m_tv = 1'b0;
        end else begin
            nf = m_f;
            popped = 1'b0;
            if (rs && !sv) begin
                if (m_stk.size() > 0) begin
                    nf = m_stk.pop_back();
                    popped = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end
            if (!popped && we) begin
                for (int b = 0; b < 3; b++) if (mask[b]) nf[b] = vals[b];
            end
            if (sv && !rs) begin
                if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                else m_stk.push_back(m_f);
            end
            m_take = cv ? ref_cond(cc, nf) : 1'b0;
            m_tv   = cv;
            m_f    = nf;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
        tests_run++;
        if ({zf, sf, cf} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags got %b want 000", {zf, sf, cf});
        end
        tests_run++;
        if ({take, take_vld, ovf, unf} !== 4'b0000 || depth !== '0) begin
            tests_failed++;
            $display("FAIL reset_misc got take=%b tv=%b ovf=%b unf=%b depth=%0d want all 0", take, take_vld, ovf, unf, depth);
        end
    endtask

    task automatic test_alu_write();
        cyc(1'b1, 1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 1'b0, 3'd0);
        tests_run++;
        if ({zf, sf, cf} !== 3'b101) begin
            tests_failed++; $display("FAIL alu_full got %b want 101", {zf, sf, cf});
        end
        cyc(1'b1, 1'b1, 3'b001, 3'b110, 1'b0, 1'b0, 1'b0, 3'd0);
        tests_run++;
        if ({zf, sf, cf} !== 3'b100) begin
            tests_failed++; $display("FAIL alu_mask got %b want 100", {zf, sf, cf});
        end
    endtask

    task automatic test_save_restore();
        cyc(1'b1, 1'b1, 3'b111, 3'b010, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0);
        tests_run++;
        if (depth !== 3'd1 || {zf, sf, cf} !== 3'b010) begin
            tests_failed++; $display("FAIL sr_save got depth=%0d flags=%b want 1 010", depth, {zf, sf, cf});
        end
        cyc(1'b1, 1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 1'b0, 3'd0);
        tests_run++;
        if (depth !== 3'd1 || {zf, sf, cf} !== 3'b101) begin
            tests_failed++; $display("FAIL sr_alu got depth=%0d flags=%b want 1 101", depth, {zf, sf, cf});
        end
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0);
        tests_run++;
        if (depth !== 3'd0 || {zf, sf, cf} !== 3'b010) begin
            tests_failed++; $display("FAIL sr_restore got depth=%0d flags=%b want 0 010", depth, {zf, sf, cf});
        end
    endtask

    task automatic test_stall();
        cyc(1'b1, 1'b1, 3'b111, 3'b011, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 3'b111, 3'b111, 1'b0, 1'b1, 1'b0, 3'd0);
        tests_run++;
        if (obs_stall !== 1'b1) begin
            tests_failed++; $display("FAIL stall_asserted got %b want 1", obs_stall);
        end
        tests_run++;
        if ({zf, sf, cf} !== 3'b011 || depth !== 3'd0) begin
            tests_failed++; $display("FAIL stall_pop got flags=%b depth=%0d want 011 0", {zf, sf, cf}, depth);
        end
        cyc(1'b1, 1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 3'd0);
        tests_run++;
        if (obs_stall !== 1'b0 || {zf, sf, cf} !== 3'b111) begin
            tests_failed++; $display("FAIL stall_retry got stall=%b flags=%b want 0 111", obs_stall, {zf, sf, cf});
        end
        // restore on empty stack must not stall the ALU
        cyc(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0);
        tests_run++;
        if (obs_stall !== 1'b0 || {zf, sf, cf} !== 3'b101 || unf !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_empty got stall=%b flags=%b unf=%b want 0 101 1", obs_stall, {zf, sf, cf}, unf);
        end
    endtask

    task automatic test_cond_forward();
        cyc(1'b1, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 3'd1);
        tests_run++;
        if (take_vld !== 1'b1 || take !== 1'b1) begin
            tests_failed++; $display("FAIL cond_fwd got tv=%b take=%b want 1 1", take_vld, take);
        end
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'd7);
        tests_run++;
        if (take_vld !== 1'b1 || take !== 1'b0) begin
            tests_failed++; $display("FAIL cond_nv got tv=%b take=%b want 1 0", take_vld, take);
        end
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0);
        tests_run++;
        if (take_vld !== 1'b1 || take !== 1'b1) begin
            tests_failed++; $display("FAIL cond_al got tv=%b take=%b want 1 1", take_vld, take);
        end
        idle();
        tests_run++;
        if (take_vld !== 1'b0) begin
            tests_failed++; $display("FAIL cond_pulse got tv=%b want 0", take_vld);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [2:0] first_saved;
        cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
        first_saved = 3'b000;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 3'b111, 3'(i + 1), 1'b1, 1'b0, 1'b0, 3'd0);
        end
        tests_run++;
        if (depth !== 3'd4 || ovf !== 1'b1 || unf !== 1'b0) begin
            tests_failed++; $display("FAIL ovf got depth=%0d ovf=%b unf=%b want 4 1 0", depth, ovf, unf);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0);
        end
        tests_run++;
        if ({zf, sf, cf} !== first_saved || depth !== 3'd0 || unf !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain got flags=%b depth=%0d unf=%b want %b 0 0", {zf, sf, cf}, depth, unf, first_saved);
        end
        cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0);
        tests_run++;
        if ({zf, sf, cf} !== first_saved || unf !== 1'b1) begin
            tests_failed++; $display("FAIL unf got flags=%b unf=%b want %b 1", {zf, sf, cf}, unf, first_saved);
        end
        idle(); idle();
        tests_run++;
        if (ovf !== 1'b1 || unf !== 1'b1) begin
            tests_failed++; $display("FAIL sticky got ovf=%b unf=%b want 1 1", ovf, unf);
        end
    endtask

    task automatic test_reset_override();
        cyc(1'b1, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 3'd0);
        tests_run++;
        if ({zf, sf, cf, take, take_vld, ovf, unf} !== 7'b0 || depth !== '0) begin
            tests_failed++;
            $display("FAIL reset_override got flags=%b take=%b tv=%b ovf=%b unf=%b depth=%0d want all 0",
                     {zf, sf, cf}, take, take_vld, ovf, unf, depth);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            logic rn, we, sv, rs, cv;
            logic [2:0] mask, vals, cc;
            rn   = ($urandom_range(0, 59) != 0);
            we   = $urandom_range(0, 1) == 1;
            mask = 3'($urandom_range(0, 7));
            vals = 3'($urandom_range(0, 7));
            sv   = ($urandom_range(0, 3) == 0);
            rs   = ($urandom_range(0, 3) == 0);
            cv   = $urandom_range(0, 1) == 1;
            cc   = 3'($urandom_range(0, 7));
            cyc(rn, we, mask, vals, sv, rs, cv, cc);
            tests_run++;
            if (obs_stall !== exp_stall || {zf, sf, cf} !== m_f || depth !== (PW+1)'(m_stk.size()) ||
                ovf !== m_ovf || unf !== m_unf || take_vld !== m_tv || (m_tv && take !== m_take)) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL rand[%0d] got stall=%b flags=%b depth=%0d ovf=%b unf=%b tv=%b take=%b want %b %b %0d %b %b %b %b",
                             i, obs_stall, {zf, sf, cf}, depth, ovf, unf, take_vld, take,
                             exp_stall, m_f, m_stk.size(), m_ovf, m_unf, m_tv, m_take);
                errs++;
            end
        end
    endtask

    initial begin
        m_f = 3'b000; m_ovf = 1'b0; m_unf = 1'b0; m_take = 1'b0; m_tv = 1'b0;
        exp_stall = 1'b0; obs_stall = 1'b0;
        test_reset();
        test_alu_write();
        test_save_restore();
        test_stall();
        test_cond_forward();
        test_overflow_underflow();
        test_reset_override();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
